// File: rtl/wb_arbiter_if.sv
// Bundle of the two result streams, the register-file write port and the forwarding
// lookup between the execute/load-store units and the writeback arbiter.
interface wb_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic            exu_valid_i;
    logic [4:0]      exu_rd_addr_i;
    logic [XLEN-1:0] exu_rd_data_i;
    logic            exu_ready_o;

    logic            lsu_valid_i;
    logic [4:0]      lsu_rd_addr_i;
    logic [XLEN-1:0] lsu_rd_data_i;
    logic            lsu_ready_o;

    logic            rd_wr_en_o;
    logic [4:0]      rd_wr_addr_o;
    logic [XLEN-1:0] rd_wr_data_o;

    logic [4:0]      fwd_rs_addr_i;
    logic            fwd_hit_o;
    logic [XLEN-1:0] fwd_data_o;

    logic            addr_err_o;

    modport slave (
        input  exu_valid_i, exu_rd_addr_i, exu_rd_data_i,
        input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        input  fwd_rs_addr_i,
        output exu_ready_o, lsu_ready_o,
        output rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o,
        output fwd_hit_o, fwd_data_o, addr_err_o
    );

    modport master (
        output exu_valid_i, exu_rd_addr_i, exu_rd_data_i,
        output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        output fwd_rs_addr_i,
        input  exu_ready_o, lsu_ready_o,
        input  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o,
        input  fwd_hit_o, fwd_data_o, addr_err_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results into one registered register-file write
// per cycle, LSU first, with a one-entry skid buffer per source and write forwarding.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int REG_N = 32
) (
    input logic         clk_i,
    input logic         rst_n_i,
    wb_arbiter_if.slave bus
);
    localparam logic [5:0] REG_LIM = 6'(REG_N);

    logic            exu_skid_full, lsu_skid_full;
    logic [4:0]      exu_skid_addr, lsu_skid_addr;
    logic [XLEN-1:0] exu_skid_data, lsu_skid_data;

    logic            exu_live_acc, lsu_live_acc;
    logic            exu_cand, lsu_cand;
    logic [4:0]      exu_cand_addr, lsu_cand_addr;
    logic [XLEN-1:0] exu_cand_data, lsu_cand_data;
    logic            exu_win, lsu_win, win;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;
    logic            win_wr_en, err_set;

    logic            wr_en_q;
    logic [4:0]      wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic            addr_err_q;
    logic            fwd_hit;

    always_comb begin
        exu_live_acc  = bus.exu_valid_i && !exu_skid_full;
        lsu_live_acc  = bus.lsu_valid_i && !lsu_skid_full;

        // A full skid always shadows the live input, keeping per-source order.
        exu_cand      = exu_skid_full || bus.exu_valid_i;
        exu_cand_addr = exu_skid_full ? exu_skid_addr : bus.exu_rd_addr_i;
        exu_cand_data = exu_skid_full ? exu_skid_data : bus.exu_rd_data_i;
        lsu_cand      = lsu_skid_full || bus.lsu_valid_i;
        lsu_cand_addr = lsu_skid_full ? lsu_skid_addr : bus.lsu_rd_addr_i;
        lsu_cand_data = lsu_skid_full ? lsu_skid_data : bus.lsu_rd_data_i;

        lsu_win   = lsu_cand;
        exu_win   = exu_cand && !lsu_cand;
        win       = lsu_win || exu_win;
        win_addr  = lsu_win ? lsu_cand_addr : exu_cand_addr;
        win_data  = lsu_win ? lsu_cand_data : exu_cand_data;
        win_wr_en = win && (win_addr != 5'd0) && ({1'b0, win_addr} < REG_LIM);

        // Flag illegal destinations at acceptance; skid entries were flagged when they arrived.
        err_set = (lsu_live_acc && ({1'b0, bus.lsu_rd_addr_i} >= REG_LIM)) ||
                  (exu_live_acc && ({1'b0, bus.exu_rd_addr_i} >= REG_LIM));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exu_skid_full <= 1'b0;
            exu_skid_addr <= 5'd0;
            exu_skid_data <= '0;
        end else if (exu_live_acc && !exu_win) begin
            exu_skid_full <= 1'b1;
            exu_skid_addr <= bus.exu_rd_addr_i;
            exu_skid_data <= bus.exu_rd_data_i;
        end else if (exu_skid_full && exu_win) begin
            exu_skid_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lsu_skid_full <= 1'b0;
            lsu_skid_addr <= 5'd0;
            lsu_skid_data <= '0;
        end else if (lsu_live_acc && !lsu_win) begin
            lsu_skid_full <= 1'b1;
            lsu_skid_addr <= bus.lsu_rd_addr_i;
            lsu_skid_data <= bus.lsu_rd_data_i;
        end else if (lsu_skid_full && lsu_win) begin
            lsu_skid_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wr_en_q    <= win_wr_en;
            addr_err_q <= addr_err_q || err_set;
            if (win) begin
                wr_addr_q <= win_addr;
                wr_data_q <= win_data;
            end
        end
    end

    assign fwd_hit = wr_en_q && (wr_addr_q == bus.fwd_rs_addr_i) && (bus.fwd_rs_addr_i != 5'd0);

    assign bus.exu_ready_o  = !exu_skid_full;
    assign bus.lsu_ready_o  = !lsu_skid_full;
    assign bus.rd_wr_en_o   = wr_en_q;
    assign bus.rd_wr_addr_o = wr_addr_q;
    assign bus.rd_wr_data_o = wr_data_q;
    assign bus.fwd_hit_o    = fwd_hit;
    assign bus.fwd_data_o   = fwd_hit ? wr_data_q : '0;
    assign bus.addr_err_o   = addr_err_q;
endmodule
